// File: rtl/vend_pkg.sv
// Shared coin encodings, coin values and FSM state encoding for the coin vendor.
package vend_pkg;

  typedef enum logic [1:0] {
    CoinNone    = 2'b00,
    CoinNickel  = 2'b01,
    CoinQuarter = 2'b10,
    CoinDime    = 2'b11
  } coin_e;

  localparam logic [2:0] NickelVal  = 3'd1;
  localparam logic [2:0] DimeVal    = 3'd2;
  localparam logic [2:0] QuarterVal = 3'd5;

  typedef enum logic [1:0] {
    StIdle   = 2'b00,
    StAccum  = 2'b01,
    StVend   = 2'b10,
    StChange = 2'b11
  } state_e;

  // Value of a coin in nickels.
  function automatic logic [2:0] coin_value(input coin_e c);
    logic [2:0] v;
    unique case (c)
      CoinNickel:  v = NickelVal;
      CoinDime:    v = DimeVal;
      CoinQuarter: v = QuarterVal;
      default:     v = 3'd0;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/coin_vend_fsm_if.sv
// Coin-in / vend-out bundle between the coin front end and the vending controller.
interface coin_vend_fsm_if #(
  parameter int unsigned CREDIT_W = 5
);
  logic [1:0]          coin;
  logic                cancel;
  logic                dispense;
  logic                change_n;
  logic [CREDIT_W-1:0] credit;
  logic                busy;

  modport master (
    output coin, cancel,
    input  dispense, change_n, credit, busy
  );

  modport slave (
    input  coin, cancel,
    output dispense, change_n, credit, busy
  );
endinterface

// File: rtl/vend_change_ctr.sv
// Down-counter holding the number of nickels still to be returned.
module vend_change_ctr #(
  parameter int unsigned W = 6
) (
  input  logic         clock,
  input  logic         clear,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero,
  output logic         last
);
  logic [W-1:0] count_q;

  // Load has priority over decrement; never decrement below zero.
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      count_q <= '0;
    end else if (load) begin
      count_q <= load_val;
    end else if (dec && !zero) begin
      count_q <= count_q - W'(1);
    end
  end

  assign zero = (count_q == '0);
  assign last = (count_q == W'(1));
endmodule

// File: rtl/coin_vend_fsm.sv
// Coin-operated vending controller: accumulates credit, vends, returns change in nickels.
module coin_vend_fsm
  import vend_pkg::*;
#(
  parameter int unsigned PRICE_N  = 3,
  parameter int unsigned CREDIT_W = 5
) (
  input  logic           clock,
  input  logic           clear,
  coin_vend_fsm_if.slave bus
);
  localparam int unsigned SumW = CREDIT_W + 1;

  state_e              state_q, state_d;
  logic [CREDIT_W-1:0] credit_q, credit_d;
  logic                dispense_q, dispense_d;
  logic                change_n_q, change_n_d;
  logic                busy_q, busy_d;

  logic [SumW-1:0] sum;
  logic            ctr_load, ctr_dec, ctr_zero, ctr_last;
  logic [SumW-1:0] ctr_load_val;

  // Widened so a quarter on top of near-price credit cannot wrap.
  assign sum = {1'b0, credit_q} + SumW'(coin_value(coin_e'(bus.coin)));

  vend_change_ctr #(
    .W(SumW)
  ) u_change_ctr (
    .clock    (clock),
    .clear    (clear),
    .load     (ctr_load),
    .load_val (ctr_load_val),
    .dec      (ctr_dec),
    .zero     (ctr_zero),
    .last     (ctr_last)
  );

  // State, credit and all outputs are registered together.
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      state_q    <= StIdle;
      credit_q   <= '0;
      dispense_q <= 1'b0;
      change_n_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      credit_q   <= credit_d;
      dispense_q <= dispense_d;
      change_n_q <= change_n_d;
      busy_q     <= busy_d;
    end
  end

  // Next-state, credit update and change-counter control.
  always_comb begin
    state_d      = state_q;
    credit_d     = credit_q;
    ctr_load     = 1'b0;
    ctr_load_val = sum;
    ctr_dec      = 1'b0;
    unique case (state_q)
      StIdle, StAccum: begin
        // Cancel beats vending; a zero sum means idle with no coin, where cancel is moot.
        if (bus.cancel && (sum != '0)) begin
          state_d      = StChange;
          credit_d     = '0;
          ctr_load     = 1'b1;
          ctr_load_val = sum;
        end else if (sum >= SumW'(PRICE_N)) begin
          state_d      = StVend;
          credit_d     = '0;
          ctr_load     = 1'b1;
          ctr_load_val = sum - SumW'(PRICE_N);
        end else if (sum != '0) begin
          state_d  = StAccum;
          credit_d = sum[CREDIT_W-1:0];
        end
      end
      StVend: begin
        state_d = ctr_zero ? StIdle : StChange;
      end
      StChange: begin
        ctr_dec = 1'b1;
        if (ctr_last) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Output decode from the next state so each output lands in a register.
  always_comb begin
    dispense_d = (state_d == StVend);
    change_n_d = (state_d == StChange);
    busy_d     = (state_d == StVend) || (state_d == StChange);
  end

  assign bus.dispense = dispense_q;
  assign bus.change_n = change_n_q;
  assign bus.credit   = credit_q;
  assign bus.busy     = busy_q;
endmodule

// File: tb/tb_coin_vend_fsm.sv
// Directed bench for coin_vend_fsm at PRICE_N=3 with hand-computed expectations.
module tb_coin_vend_fsm;
  import vend_pkg::*;

  logic clock;
  logic clear;
  int   n_assert;
  int   n_fail;

  coin_vend_fsm_if #(.CREDIT_W(5)) bus ();

  coin_vend_fsm #(
    .PRICE_N  (3),
    .CREDIT_W (5)
  ) dut (
    .clock (clock),
    .clear (clear),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic expect_out(input string tag, input logic d, input logic c,
                            input int unsigned cr, input logic b);
    chk({tag, ".dispense"}, 32'(bus.dispense), 32'(d));
    chk({tag, ".change_n"}, 32'(bus.change_n), 32'(c));
    chk({tag, ".credit"},   32'(bus.credit),   cr);
    chk({tag, ".busy"},     32'(bus.busy),     32'(b));
  endtask

  // Present one cycle of input, then sample just after the capturing edge.
  task automatic apply(input logic [1:0] coin, input logic cancel);
    @(negedge clock);
    bus.coin   = coin;
    bus.cancel = cancel;
    @(posedge clock);
    #1;
  endtask

  initial begin
    n_assert   = 0;
    n_fail     = 0;
    clear      = 1'b1;
    bus.coin   = CoinNone;
    bus.cancel = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    expect_out("reset", 0, 0, 0, 0);
    @(negedge clock);
    clear = 1'b0;

    // Three nickels: credit 1, 2, then vend with no change.
    apply(CoinNickel, 0);  expect_out("n3.c1", 0, 0, 1, 0);
    apply(CoinNickel, 0);  expect_out("n3.c2", 0, 0, 2, 0);
    apply(CoinNickel, 0);  expect_out("n3.vend", 1, 0, 0, 1);
    apply(CoinNone, 0);    expect_out("n3.idle", 0, 0, 0, 0);
    apply(CoinNone, 0);    expect_out("n3.nochg", 0, 0, 0, 0);

    // Two dimes: vend, one nickel back.
    apply(CoinDime, 0);    expect_out("dd.c2", 0, 0, 2, 0);
    apply(CoinDime, 0);    expect_out("dd.vend", 1, 0, 0, 1);
    apply(CoinNone, 0);    expect_out("dd.chg1", 0, 1, 0, 1);
    apply(CoinNone, 0);    expect_out("dd.idle", 0, 0, 0, 0);

    // Quarter: vend, two nickels back.
    apply(CoinQuarter, 0); expect_out("q.vend", 1, 0, 0, 1);
    apply(CoinNone, 0);    expect_out("q.chg1", 0, 1, 0, 1);
    apply(CoinNone, 0);    expect_out("q.chg2", 0, 1, 0, 1);
    apply(CoinNone, 0);    expect_out("q.idle", 0, 0, 0, 0);

    // Nickel then dime+cancel: sum equals price but cancel wins, 3 nickels refunded.
    apply(CoinNickel, 0);  expect_out("nc.c1", 0, 0, 1, 0);
    apply(CoinDime, 1);    expect_out("nc.ref1", 0, 1, 0, 1);
    apply(CoinNone, 0);    expect_out("nc.ref2", 0, 1, 0, 1);
    apply(CoinNone, 0);    expect_out("nc.ref3", 0, 1, 0, 1);
    apply(CoinNone, 0);    expect_out("nc.idle", 0, 0, 0, 0);

    // Quarter, then dimes while busy: dimes discarded, exactly two change pulses.
    apply(CoinQuarter, 0); expect_out("qd.vend", 1, 0, 0, 1);
    apply(CoinDime, 0);    expect_out("qd.chg1", 0, 1, 0, 1);
    apply(CoinDime, 1);    expect_out("qd.chg2", 0, 1, 0, 1);
    apply(CoinDime, 0);    expect_out("qd.done", 0, 0, 0, 0);
    apply(CoinNone, 0);    expect_out("qd.final", 0, 0, 0, 0);

    // Cancel in idle with no coin does nothing.
    apply(CoinNone, 1);    expect_out("idle.cancel", 0, 0, 0, 0);

    // Quarter, then clear during the first change pulse: outputs drop without a clock edge.
    apply(CoinQuarter, 0); expect_out("qc.vend", 1, 0, 0, 1);
    apply(CoinNone, 0);    expect_out("qc.chg1", 0, 1, 0, 1);
    #2;
    clear = 1'b1;
    #1;
    expect_out("qc.clear", 0, 0, 0, 0);
    @(negedge clock);
    clear = 1'b0;
    apply(CoinNickel, 0);  expect_out("qc.n1", 0, 0, 1, 0);
    apply(CoinNone, 0);    expect_out("qc.hold", 0, 0, 1, 0);

    // Cancel in accum refunds the single nickel.
    apply(CoinNone, 1);    expect_out("ac.ref1", 0, 1, 0, 1);
    apply(CoinNone, 0);    expect_out("ac.idle", 0, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
